// File: rtl/rob_pkg.sv
// Shared constants for the reorder buffer: tag width, the NONE tag,
// instruction-type encodings and register-number width.
package rob_pkg;

  localparam int ROB_SIZE_WIDTH = 3;
  localparam int REG_NUM_WIDTH  = 5;

  // All-ones tag means "no dependency" and is never allocated, so the
  // buffer holds one entry fewer than the tag space.
  localparam logic [ROB_SIZE_WIDTH-1:0] ROB_NONE = '1;
  localparam int ROB_DEPTH = (1 << ROB_SIZE_WIDTH) - 1;

  localparam logic [1:0] ROB_TYPE_REG    = 2'd0;
  localparam logic [1:0] ROB_TYPE_STORE  = 2'd1;
  localparam logic [1:0] ROB_TYPE_BRANCH = 2'd2;

endpackage

// File: rtl/rob.sv
// Reorder buffer: allocates tags in program order, collects ALU/LSB
// writebacks, retires one entry per cycle to the register file or the
// LSB, and raises a flush when a mispredicted branch retires.
// Optional feature: define ROB_COMMIT_CNT_EN to add a 32-bit retired
// instruction counter on output commit_cnt.
module rob
  import rob_pkg::*;
(
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dec_valid,
  input  logic [1:0]                dec_type,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
  input  logic                      dec_ready,
  input  logic [31:0]               dec_value,
  input  logic [31:0]               dec_pc_alt,
  input  logic                      cdb_alu_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_tag,
  input  logic [31:0]               cdb_alu_value,
  input  logic                      cdb_alu_mispred,
  input  logic                      cdb_lsb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_lsb_tag,
  input  logic [31:0]               cdb_lsb_value,
  input  logic [ROB_SIZE_WIDTH-1:0] query_tag1,
  input  logic [ROB_SIZE_WIDTH-1:0] query_tag2,
  output logic                      query_ready1,
  output logic [31:0]               query_value1,
  output logic                      query_ready2,
  output logic [31:0]               query_value2,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail,
  output logic                      rob_valid,
  output logic [REG_NUM_WIDTH-1:0]  rob_rd,
  output logic [31:0]               rob_value,
  output logic [ROB_SIZE_WIDTH-1:0] rob_dependency,
  output logic                      store_commit_valid,
  output logic [ROB_SIZE_WIDTH-1:0] store_commit_tag,
  output logic                      need_flush_out,
  output logic [31:0]               flush_pc
`ifdef ROB_COMMIT_CNT_EN
  ,
  output logic [31:0]               commit_cnt
`endif
);

  typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;

  localparam tag_t LAST_TAG   = tag_t'(ROB_DEPTH - 1);
  localparam tag_t FULL_COUNT = tag_t'(ROB_DEPTH);

  // Per-entry status flags (reset) and payload (not reset).
  logic [ROB_DEPTH-1:0]     busy;
  logic [ROB_DEPTH-1:0]     ready;
  logic [ROB_DEPTH-1:0]     mispred;
  logic [1:0]               etype   [ROB_DEPTH];
  logic [REG_NUM_WIDTH-1:0] erd     [ROB_DEPTH];
  logic [31:0]              evalue  [ROB_DEPTH];
  logic [31:0]              epc_alt [ROB_DEPTH];

  tag_t head;
  tag_t tail;
  tag_t count;

  logic accept_in;
  logic issue;
  logic alu_wr;
  logic lsb_wr;
  logic commit;
  logic flush;

  // Pointers wrap after the last real entry so NONE is never produced.
  function automatic tag_t next_ptr(input tag_t p);
    return (p == LAST_TAG) ? '0 : p + 1'b1;
  endfunction

  // Issue and writeback are dropped while stalled or while the flush
  // pulse is out; CDB beats only land on live entries.
  assign accept_in = rdy_in && !need_flush_out;
  assign rob_full  = (count == FULL_COUNT);
  assign rob_tail  = tail;
  assign issue     = accept_in && dec_valid && !rob_full;
  assign alu_wr    = accept_in && cdb_alu_valid && (cdb_alu_tag != ROB_NONE)
                     && busy[cdb_alu_tag];
  assign lsb_wr    = accept_in && cdb_lsb_valid && (cdb_lsb_tag != ROB_NONE)
                     && busy[cdb_lsb_tag];
  assign commit    = rdy_in && busy[head] && ready[head];
  assign flush     = commit && (etype[head] == ROB_TYPE_BRANCH) && mispred[head];

  // Operand lookup: stored result first, then a same-cycle CDB bypass
  // (LSB takes precedence, matching the writeback order).
  function automatic logic [32:0] lookup(input tag_t t);
    logic [32:0] r;
    // NOTE: default assignment first, so no path through this logic can infer a latch.
    r = {1'b0, evalue[(t == ROB_NONE) ? '0 : t]};
    if (t == ROB_NONE)
      r = {1'b1, 32'd0};
    else if (ready[t])
      r = {1'b1, evalue[t]};
    else if (!need_flush_out && cdb_lsb_valid && (cdb_lsb_tag == t))
      r = {1'b1, cdb_lsb_value};
    else if (!need_flush_out && cdb_alu_valid && (cdb_alu_tag == t))
      r = {1'b1, cdb_alu_value};
    return r;
  endfunction

  // Combinational operand queries for the two source registers.
  always_comb begin
    {query_ready1, query_value1} = lookup(query_tag1);
    {query_ready2, query_value2} = lookup(query_tag2);
  end

  // Control state: pointers, occupancy and per-entry status flags.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      ready   <= '0;
      mispred <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      if (issue) begin
        busy[tail]    <= 1'b1;
        ready[tail]   <= dec_ready;
        mispred[tail] <= 1'b0;
        tail          <= next_ptr(tail);
      end
      if (alu_wr) begin
        ready[cdb_alu_tag]   <= 1'b1;
        mispred[cdb_alu_tag] <= cdb_alu_mispred;
      end
      if (lsb_wr)
        ready[cdb_lsb_tag] <= 1'b1;
      if (commit) begin
        busy[head] <= 1'b0;
        head       <= next_ptr(head);
      end
      count <= count + tag_t'(issue) - tag_t'(commit);
    end
  end

  // Entry payload; the reserved type code is stored as REG.
  always_ff @(posedge clk_in) begin
    // NOTE: payload arrays are not reset; busy/ready gate every use of them.
    if (issue) begin
      etype[tail]   <= (dec_type == ROB_TYPE_STORE || dec_type == ROB_TYPE_BRANCH)
                       ? dec_type : ROB_TYPE_REG;
      erd[tail]     <= dec_rd;
      evalue[tail]  <= dec_value;
      epc_alt[tail] <= dec_pc_alt;
    end
    if (alu_wr)
      evalue[cdb_alu_tag] <= cdb_alu_value;
    if (lsb_wr)
      evalue[cdb_lsb_tag] <= cdb_lsb_value;
  end

  // Registered retire outputs: one-cycle pulses, data held between them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rob_valid          <= 1'b0;
      rob_rd             <= '0;
      rob_value          <= '0;
      rob_dependency     <= ROB_NONE;
      store_commit_valid <= 1'b0;
      store_commit_tag   <= '0;
      need_flush_out     <= 1'b0;
      flush_pc           <= '0;
    end else begin
      rob_valid          <= 1'b0;
      store_commit_valid <= 1'b0;
      need_flush_out     <= 1'b0;
      if (commit) begin
        if (etype[head] == ROB_TYPE_STORE) begin
          store_commit_valid <= 1'b1;
          store_commit_tag   <= head;
        end else begin
          rob_valid      <= 1'b1;
          rob_rd         <= erd[head];
          rob_value      <= evalue[head];
          rob_dependency <= head;
        end
        if (flush) begin
          need_flush_out <= 1'b1;
          flush_pc       <= epc_alt[head];
        end
      end
    end
  end

`ifdef ROB_COMMIT_CNT_EN
  // Retired-instruction counter; survives flushes, wraps naturally.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      commit_cnt <= '0;
    else if (commit)
      commit_cnt <= commit_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios followed by random
// traffic, all compared against a program-order queue model.
module tb_rob;
  import rob_pkg::*;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                      rst_in, rdy_in;
  logic                      dec_valid, dec_ready;
  logic [1:0]                dec_type;
  logic [REG_NUM_WIDTH-1:0]  dec_rd;
  logic [31:0]               dec_value, dec_pc_alt;
  logic                      cdb_alu_valid, cdb_alu_mispred, cdb_lsb_valid;
  logic [ROB_SIZE_WIDTH-1:0] cdb_alu_tag, cdb_lsb_tag;
  logic [31:0]               cdb_alu_value, cdb_lsb_value;
  logic [ROB_SIZE_WIDTH-1:0] query_tag1, query_tag2;
  logic                      query_ready1, query_ready2;
  logic [31:0]               query_value1, query_value2;
  logic                      rob_full, rob_valid, store_commit_valid, need_flush_out;
  logic [ROB_SIZE_WIDTH-1:0] rob_tail, rob_dependency, store_commit_tag;
  logic [REG_NUM_WIDTH-1:0]  rob_rd;
  logic [31:0]               rob_value, flush_pc;
`ifdef ROB_COMMIT_CNT_EN
  logic [31:0]               commit_cnt;
`endif

  rob dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_ready(dec_ready), .dec_value(dec_value), .dec_pc_alt(dec_pc_alt),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag),
    .cdb_alu_value(cdb_alu_value), .cdb_alu_mispred(cdb_alu_mispred),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag),
    .cdb_lsb_value(cdb_lsb_value),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_value1(query_value1),
    .query_ready2(query_ready2), .query_value2(query_value2),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .rob_valid(rob_valid), .rob_rd(rob_rd), .rob_value(rob_value),
    .rob_dependency(rob_dependency),
    .store_commit_valid(store_commit_valid), .store_commit_tag(store_commit_tag),
    .need_flush_out(need_flush_out), .flush_pc(flush_pc)
`ifdef ROB_COMMIT_CNT_EN
    , .commit_cnt(commit_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: live instructions in program order.
  typedef struct {
    logic [ROB_SIZE_WIDTH-1:0] tag;
    logic [1:0]                typ;
    logic [4:0]                rd;
    logic [31:0]               value;
    logic [31:0]               pc_alt;
    bit                        ready;
    bit                        mispred;
  } ent_t;

  ent_t        q[$];
  int          m_tail = 0;
  bit          m_flush_prev = 0;
  bit          m_known = 0;
  logic [31:0] m_cnt = 0;

  bit          e_reset, e_valid, e_store, e_flush;
  logic [4:0]  e_rd;
  logic [31:0] e_value, e_fpc;
  logic [ROB_SIZE_WIDTH-1:0] e_dep, e_sct;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic void model_query(input logic [ROB_SIZE_WIDTH-1:0] t,
                                      output bit r, output logic [31:0] v);
    r = 0;
    v = 0;
    if (t == ROB_NONE) begin
      r = 1;
      return;
    end
    foreach (q[i])
      if (q[i].tag == t && q[i].ready) begin
        r = 1;
        v = q[i].value;
        return;
      end
    if (!m_flush_prev && cdb_lsb_valid && cdb_lsb_tag == t) begin
      r = 1;
      v = cdb_lsb_value;
    end else if (!m_flush_prev && cdb_alu_valid && cdb_alu_tag == t) begin
      r = 1;
      v = cdb_alu_value;
    end
  endfunction

  // Advance the model across one clock edge using the driven inputs.
  function automatic void model_step();
    ent_t e;
    ent_t n_ent;
    int   n;
    bit   accept, do_commit;
    e_valid = 0;
    e_store = 0;
    e_flush = 0;
    e_reset = 0;
    if (rst_in) begin
      q.delete();
      m_tail = 0;
      m_flush_prev = 0;
      m_cnt = 0;
      e_reset = 1;
      m_known = 1;
      return;
    end
    if (!rdy_in) begin
      m_flush_prev = 0;
      return;
    end
    accept = !m_flush_prev;
    n = q.size();
    do_commit = (n > 0) && q[0].ready;
    if (do_commit) begin
      e = q[0];
      m_cnt++;
      if (e.typ == ROB_TYPE_STORE) begin
        e_store = 1;
        e_sct = e.tag;
      end else begin
        e_valid = 1;
        e_rd = e.rd;
        e_value = e.value;
        e_dep = e.tag;
      end
      if (e.typ == ROB_TYPE_BRANCH && e.mispred) begin
        e_flush = 1;
        e_fpc = e.pc_alt;
      end
    end
    if (e_flush) begin
      q.delete();
      m_tail = 0;
    end else begin
      if (do_commit) void'(q.pop_front());
      if (accept && cdb_alu_valid)
        foreach (q[i]) if (q[i].tag == cdb_alu_tag) begin
          q[i].ready = 1;
          q[i].value = cdb_alu_value;
          q[i].mispred = cdb_alu_mispred;
        end
      if (accept && cdb_lsb_valid)
        foreach (q[i]) if (q[i].tag == cdb_lsb_tag) begin
          q[i].ready = 1;
          q[i].value = cdb_lsb_value;
        end
      if (accept && dec_valid && n < ROB_DEPTH) begin
        n_ent.tag = ROB_SIZE_WIDTH'(m_tail);
        n_ent.typ = dec_type;
        n_ent.rd = dec_rd;
        n_ent.value = dec_value;
        n_ent.pc_alt = dec_pc_alt;
        n_ent.ready = dec_ready;
        n_ent.mispred = 0;
        q.push_back(n_ent);
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end
    end
    m_flush_prev = e_flush;
  endfunction

  // One clock: check combinational outputs, step model, check registered outputs.
  task automatic cycle();
    bit          r;
    logic [31:0] v;
    #1;
    if (m_known) begin
      check("rob_full", rob_full, (q.size() == ROB_DEPTH));
      check("rob_tail", rob_tail, m_tail);
      model_query(query_tag1, r, v);
      check("query_ready1", query_ready1, r);
      if (r) check("query_value1", query_value1, v);
      model_query(query_tag2, r, v);
      check("query_ready2", query_ready2, r);
      if (r) check("query_value2", query_value2, v);
    end
    model_step();
    @(posedge clk_in);
    #1;
    if (e_reset) begin
      check("rst_rob_valid", rob_valid, 0);
      check("rst_store_valid", store_commit_valid, 0);
      check("rst_flush", need_flush_out, 0);
      check("rst_rob_rd", rob_rd, 0);
      check("rst_rob_value", rob_value, 0);
      check("rst_rob_dep", rob_dependency, ROB_NONE);
      check("rst_store_tag", store_commit_tag, 0);
      check("rst_flush_pc", flush_pc, 0);
      check("rst_full", rob_full, 0);
      check("rst_tail", rob_tail, 0);
    end else begin
      check("rob_valid", rob_valid, e_valid);
      check("store_commit_valid", store_commit_valid, e_store);
      check("need_flush_out", need_flush_out, e_flush);
      if (e_valid) begin
        check("rob_rd", rob_rd, e_rd);
        check("rob_value", rob_value, e_value);
        check("rob_dependency", rob_dependency, e_dep);
      end
      if (e_store) check("store_commit_tag", store_commit_tag, e_sct);
      if (e_flush) check("flush_pc", flush_pc, e_fpc);
    end
`ifdef ROB_COMMIT_CNT_EN
    check("commit_cnt", commit_cnt, m_cnt);
`endif
  endtask

  task automatic idle_inputs();
    rst_in = 0; rdy_in = 1;
    dec_valid = 0; dec_type = ROB_TYPE_REG; dec_rd = 0; dec_ready = 0;
    dec_value = 0; dec_pc_alt = 0;
    cdb_alu_valid = 0; cdb_alu_tag = 0; cdb_alu_value = 0; cdb_alu_mispred = 0;
    cdb_lsb_valid = 0; cdb_lsb_tag = 0; cdb_lsb_value = 0;
    query_tag1 = ROB_NONE; query_tag2 = ROB_NONE;
  endtask

  task automatic issue_in(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                          input logic [31:0] val, input logic [31:0] pc);
    dec_valid = 1; dec_type = t; dec_rd = rd; dec_ready = rdy;
    dec_value = val; dec_pc_alt = pc;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1;
    cycle();
    rst_in = 0;
  endtask

  task automatic rand_inputs();
    int pend[$];
    idle_inputs();
    rdy_in = ($urandom_range(0, 7) != 0);
    dec_valid = $urandom_range(0, 1);
    dec_type = 2'($urandom_range(0, 3));
    dec_rd = 5'($urandom);
    dec_ready = ($urandom_range(0, 2) == 0);
    dec_value = $urandom;
    dec_pc_alt = $urandom;
    foreach (q[i]) if (!q[i].ready) pend.push_back(i);
    if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      int k = $urandom_range(0, pend.size() - 1);
      cdb_alu_valid = 1;
      cdb_alu_tag = q[pend[k]].tag;
      cdb_alu_value = $urandom;
      cdb_alu_mispred = ($urandom_range(0, 2) == 0);
      pend.delete(k);
    end
    if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      int k = $urandom_range(0, pend.size() - 1);
      cdb_lsb_valid = 1;
      cdb_lsb_tag = q[pend[k]].tag;
      cdb_lsb_value = $urandom;
    end
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      query_tag1 = q[$urandom_range(0, q.size() - 1)].tag;
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      query_tag2 = q[$urandom_range(0, q.size() - 1)].tag;
  endtask

  initial begin
    logic [31:0] ooo_val [3];
    ooo_val[0] = 32'h10; ooo_val[1] = 32'h11; ooo_val[2] = 32'h22;

    // Reset state.
    do_reset();

    // Ready-at-issue REG retires on the following edge.
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd5, 1'b1, 32'h1234, 32'h0); cycle();
    idle_inputs(); cycle();
    check("ready_reg_valid", rob_valid, 1);
    check("ready_reg_rd", rob_rd, 5);
    check("ready_reg_value", rob_value, 32'h1234);
    check("ready_reg_dep", rob_dependency, 0);

    // Out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); issue_in(ROB_TYPE_REG, 5'(i + 1), 1'b0, 32'h0, 32'h0); cycle();
    end
    idle_inputs(); cdb_alu_valid = 1; cdb_alu_tag = 2; cdb_alu_value = 32'h22; cycle();
    check("ooo_no_early", rob_valid, 0);
    idle_inputs(); cdb_lsb_valid = 1; cdb_lsb_tag = 1; cdb_lsb_value = 32'h11; cycle();
    idle_inputs(); cdb_alu_valid = 1; cdb_alu_tag = 0; cdb_alu_value = 32'h10; cycle();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); cycle();
      check("ooo_valid", rob_valid, 1);
      check("ooo_dep", rob_dependency, i);
      check("ooo_value", rob_value, ooo_val[i]);
    end

    // Fill to capacity, reject an 8th issue, then issue alongside a retire.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle_inputs(); issue_in(ROB_TYPE_REG, 5'(i), 1'b0, 32'h0, 32'h0); cycle();
      check("fill_tail", rob_tail, (i + 1) % 7);
    end
    check("fill_full", rob_full, 1);
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd9, 1'b1, 32'h9, 32'h0); cycle();
    check("full_reject_tail", rob_tail, 0);
    check("full_reject_full", rob_full, 1);
    idle_inputs();
    cdb_alu_valid = 1; cdb_alu_tag = 0; cdb_alu_value = 32'hA0;
    cdb_lsb_valid = 1; cdb_lsb_tag = 1; cdb_lsb_value = 32'hA1;
    cycle();
    idle_inputs(); cycle();
    check("full_first_retire", rob_full, 0);
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd10, 1'b0, 32'h0, 32'h0); cycle();
    check("issue_commit_dep", rob_dependency, 1);
    check("issue_commit_full", rob_full, 0);
    check("issue_commit_tail", rob_tail, 1);
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd11, 1'b0, 32'h0, 32'h0); cycle();
    check("refill_full", rob_full, 1);

    // Mispredicted branch with younger entries pending.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); issue_in(ROB_TYPE_REG, 5'(i + 1), 1'b1, 32'(i), 32'h0); cycle();
    end
    idle_inputs(); issue_in(ROB_TYPE_BRANCH, 5'd0, 1'b0, 32'h0, 32'h80); cycle();
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd4, 1'b0, 32'h0, 32'h0); cycle();
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd5, 1'b0, 32'h0, 32'h0); cycle();
    idle_inputs();
    cdb_alu_valid = 1; cdb_alu_tag = 3; cdb_alu_value = 32'h44; cdb_alu_mispred = 1;
    cycle();
    idle_inputs(); cycle();
    check("flush_out", need_flush_out, 1);
    check("flush_pc_val", flush_pc, 32'h80);
    check("flush_branch_dep", rob_dependency, 3);
    check("flush_tail", rob_tail, 0);
    check("flush_full", rob_full, 0);
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd7, 1'b1, 32'h77, 32'h0);
    cdb_alu_valid = 1; cdb_alu_tag = 4; cdb_alu_value = 32'h99;
    cycle();
    check("flush_issue_ignored", rob_tail, 0);
    idle_inputs(); cycle();
    check("flush_no_retire", rob_valid, 0);

    // Query bypass and NONE lookup.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); issue_in(ROB_TYPE_REG, 5'(i + 1), 1'b0, 32'h0, 32'h0); cycle();
    end
    idle_inputs();
    cdb_alu_valid = 1; cdb_alu_tag = 2; cdb_alu_value = 32'h55;
    query_tag1 = 2; query_tag2 = ROB_NONE;
    #1;
    check("bypass_ready", query_ready1, 1);
    check("bypass_value", query_value1, 32'h55);
    check("none_ready", query_ready2, 1);
    check("none_value", query_value2, 0);
    cycle();
    idle_inputs(); query_tag1 = 1; query_tag2 = 2;
    #1;
    check("pending_not_ready", query_ready1, 0);
    check("stored_value", query_value2, 32'h55);
    cycle();

    // Reset with four busy entries and a concurrent issue request.
    idle_inputs(); issue_in(ROB_TYPE_REG, 5'd4, 1'b0, 32'h0, 32'h0); cycle();
    idle_inputs(); rst_in = 1; issue_in(ROB_TYPE_REG, 5'd6, 1'b1, 32'h6, 32'h0); cycle();

    // Store retires to the LSB, not the register file.
    idle_inputs(); issue_in(ROB_TYPE_STORE, 5'd3, 1'b1, 32'h99, 32'h0); cycle();
    idle_inputs(); cycle();
    check("store_valid", store_commit_valid, 1);
    check("store_not_reg", rob_valid, 0);
    check("store_tag", store_commit_tag, 0);

    // Random traffic with stalls, flushes and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle_inputs();
        rst_in = 1;
      end else begin
        rand_inputs();
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
